// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants for the register file and its scoreboard.
// Combinational helper only; carries no state or flow control.
package cpu_pkg;
  localparam int REG_W      = 32;
  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_word_t;

  function automatic logic [REG_ADDR_W:0] popcount_regs(input logic [NUM_REGS-1:0] v);
    logic [REG_ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt = cnt + {{REG_ADDR_W{1'b0}}, v[i]};
    return cnt;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on writeback; new issue wins.
// busy/pending_cnt update one edge after the strobes; hazard is combinational; no backpressure.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  reg_addr_t             waddr,
  input  logic                  issue_valid,
  input  reg_addr_t             issue_dest,
  input  reg_addr_t             rs_a,
  input  reg_addr_t             rs_b,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  hazard,
  output logic [REG_ADDR_W:0]   pending_cnt
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_ADDR_W:0] cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (issue_valid && issue_dest == reg_addr_t'(n) && !(ZERO_REG && n == 0))
        busy_d[n] = 1'b1;
      else if (we && waddr == reg_addr_t'(n))
        busy_d[n] = 1'b0;
    end
  end

  // Counting the next state keeps pending_cnt aligned with busy on the same edge.
  assign cnt_d = popcount_regs(busy_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;
  // busy_q[0] can never be set when ZERO_REG, so a source of 0 never raises hazard.
  assign hazard      = busy_q[rs_a] | busy_q[rs_b];
endmodule

// File: rtl/reg_bank16.sv
// 16-entry register bank feeding the read-select mux, with busy scoreboard for RAW stalls.
// Writes visible one cycle after the edge (no bypass); strobe-only interface, no backpressure.
module reg_bank16
  import cpu_pkg::*;
#(
  parameter int DATA_W   = REG_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic [REG_ADDR_W-1:0] rs_a,
  input  logic [REG_ADDR_W-1:0] rs_b,
  output logic [DATA_W-1:0]     r0_q,
  output logic [DATA_W-1:0]     r1_q,
  output logic [DATA_W-1:0]     r2_q,
  output logic [DATA_W-1:0]     r3_q,
  output logic [DATA_W-1:0]     r4_q,
  output logic [DATA_W-1:0]     r5_q,
  output logic [DATA_W-1:0]     r6_q,
  output logic [DATA_W-1:0]     r7_q,
  output logic [DATA_W-1:0]     r8_q,
  output logic [DATA_W-1:0]     r9_q,
  output logic [DATA_W-1:0]     r10_q,
  output logic [DATA_W-1:0]     r11_q,
  output logic [DATA_W-1:0]     r12_q,
  output logic [DATA_W-1:0]     r13_q,
  output logic [DATA_W-1:0]     r14_q,
  output logic [DATA_W-1:0]     r15_q,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  hazard,
  output logic [REG_ADDR_W:0]   pending_cnt
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;

  // Dropping register-0 writes keeps r0 at its reset value of zero.
  assign wr_en = we && !(ZERO_REG && waddr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign r0_q  = regs_q[0];
  assign r1_q  = regs_q[1];
  assign r2_q  = regs_q[2];
  assign r3_q  = regs_q[3];
  assign r4_q  = regs_q[4];
  assign r5_q  = regs_q[5];
  assign r6_q  = regs_q[6];
  assign r7_q  = regs_q[7];
  assign r8_q  = regs_q[8];
  assign r9_q  = regs_q[9];
  assign r10_q = regs_q[10];
  assign r11_q = regs_q[11];
  assign r12_q = regs_q[12];
  assign r13_q = regs_q[13];
  assign r14_q = regs_q[14];
  assign r15_q = regs_q[15];

  reg_scoreboard #(
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .waddr       (waddr),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .rs_a        (rs_a),
    .rs_b        (rs_b),
    .busy        (busy),
    .hazard      (hazard),
    .pending_cnt (pending_cnt)
  );
endmodule

// File: doc/reg_bank16.md
Name: reg_bank16

Overview:
- 16 x 32-bit general-purpose register bank with a busy-bit scoreboard.
- Sits directly upstream of the 16:1 read-select mux in the CPU datapath.
- Exposes all 16 register values in parallel; these drive the mux data inputs, with the mux select coming from instruction decode.
- Tracks registers that have an in-flight producer and flags read-after-write hazards so decode can stall.

Parameters:
- DATA_W, 32, register width in bits.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero (writes ignored, never busy); when 0 it is an ordinary register.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- we  input  1  writeback strobe.
- waddr  input  4  writeback destination.
- wdata  input  DATA_W  writeback data.
- issue_valid  input  1  instruction issued with a destination register.
- issue_dest  input  4  destination register of the issued instruction.
- rs_a  input  4  first source register of the instruction in decode.
- rs_b  input  4  second source register of the instruction in decode.
- r0_q .. r15_q  output  DATA_W each  current register contents (16 ports, wired to mux inputs a..p in order).
- busy  output  16  scoreboard bits; bit n is set while register n has a pending writer.
- hazard  output  1  combinational: busy[rs_a] OR busy[rs_b].
- pending_cnt  output  5  number of set busy bits (0..16).

Behaviour:
- Reset (async, rst=1): all registers = 0, busy = 0, pending_cnt = 0. Outputs hold these values while rst is high. Deassertion takes effect on the next clk edge.
- Write:
  - On a rising edge with we=1, reg[waddr] <= wdata.
  - rN_q shows the new value the cycle after the edge. No write-through bypass: a read in the same cycle returns the old value.
- Scoreboard update on a rising edge, per register n:
  - set_n = issue_valid and issue_dest==n.
  - clr_n = we and waddr==n.
  - set_n=1: busy[n] <= 1. This applies even when clr_n=1, because the new producer wins over the old writeback.
  - set_n=0, clr_n=1: busy[n] <= 0.
  - Otherwise busy[n] holds.
- Writeback to a register whose busy bit is already 0 still updates data; busy stays 0.
- Issue to an already-busy register: busy stays 1. Single bit only, no counting of multiple producers.
- ZERO_REG=1:
  - r0_q is constantly 0.
  - Writes to register 0 are dropped.
  - issue_dest==0 never sets busy[0].
  - hazard ignores sources equal to 0.
- hazard is purely combinational from the registered busy state and rs_a/rs_b. It does not see same-cycle issue or writeback.
- pending_cnt is the registered popcount of the next busy state. It is updated in the same edge as busy, so it always equals the popcount of busy.
- No other latency. No handshake beyond the strobes.
- X on we or issue_valid is not supported; the bench must drive known values.

Decomposition:
- Shared package cpu_pkg:
  - REG_W=32
  - NUM_REGS=16
  - REG_ADDR_W=4
  - typedef reg_addr_t (4-bit)
  - typedef reg_word_t (32-bit)
- One natural sub-module, reg_scoreboard. It contains the busy vector, set/clr priority logic, hazard and pending_cnt.
- The top level holds the data array and instantiates reg_scoreboard.

Test Plan:
- Reset: assert rst mid-run after registers hold nonzero data and busy=16'h00F0 -> immediately all rN_q=0, busy=0, pending_cnt=0, hazard=0.
- Write/read: we=1, waddr=5, wdata=32'hDEADBEEF for one edge -> r5_q=32'hDEADBEEF next cycle, all other registers unchanged. Same-cycle observation of r5_q shows the old value.
- Hazard: issue_valid=1, issue_dest=3; next cycle rs_a=3 -> busy=16'h0008, hazard=1, pending_cnt=1. Then we=1, waddr=3, wdata=7 -> next cycle busy=0, hazard=0, r3_q=7.
- Simultaneous set/clr: register 9 busy; in one edge issue_dest=9 and we to 9 with wdata=32'h1234 -> r9_q=32'h1234, busy[9] stays 1, pending_cnt unchanged.
- Zero register (ZERO_REG=1): we to 0 with 32'hFFFFFFFF, issue_dest=0, rs_a=rs_b=0 -> r0_q=0, busy[0]=0, hazard=0.
- Full scoreboard: issue to registers 1..15 over consecutive cycles (16 cycles with ZERO_REG=0) -> pending_cnt reaches 15 (16). Writeback of each register decrements pending_cnt by 1 to 0.
